// File: rtl/mem_access_ctrl_pkg.sv
// Shared load/store definitions: ALU op codes, memory sequencer states,
// access-size encodings and byte-lane geometry for a word-only data bus.
package mem_access_ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLT = 4'd5,
      ALU_SLL = 4'd6,
      ALU_SRL = 4'd7
   } alu_ops_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_WRITE  = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4,
      ST_DONE   = 3'd5
   } mem_state_t;

   localparam logic MEM_SIZE_WORD = 1'b1;
   localparam logic MEM_SIZE_BYTE = 1'b0;

   localparam int WORD_W    = 32;
   localparam int BYTE_W    = 8;
   localparam int LANE_W    = 2;
   localparam int NUM_LANES = 4;

   // Lane 0 is bits [7:0] (little-endian), so the lane LSB is lane*8.
   function automatic logic [4:0] lane_lsb(input logic [LANE_W-1:0] lane);
      return {lane, 3'b000};
   endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// Byte-lane datapath: sign-extends the selected byte of a word for lb and
// builds the merged word for the sb read-modify-write.
module byte_lane_unit
   import mem_access_ctrl_pkg::*;
(
   input  logic [WORD_W-1:0] word_i,
   input  logic [LANE_W-1:0] lane_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [WORD_W-1:0] ext_o,
   output logic [WORD_W-1:0] merged_o
);

   logic [BYTE_W-1:0] sel_s;

   // Lane extract with sign extension, and lane replacement for stores.
   always_comb begin
      sel_s    = word_i[lane_lsb(lane_i) +: BYTE_W];
      ext_o    = {{(WORD_W-BYTE_W){sel_s[BYTE_W-1]}}, sel_s};
      merged_o = word_i;
      merged_o[lane_lsb(lane_i) +: BYTE_W] = byte_i;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the core and a word-only req/ack data bus:
// lb via lane extraction, sb via read-modify-write, with a per-phase watchdog.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_ack
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic             WD_EN    = (TIMEOUT != 0);

   mem_state_t        state_q, state_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic              size_q, size_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] baddr_q, baddr_d;
   logic [31:0]       bwdata_q, bwdata_d;

   logic [31:0]       ext_s;
   logic [31:0]       merged_s;
   logic              timeout_s;

   byte_lane_unit u_lane (
      .word_i   (bus_rdata),
      .lane_i   (lane_q),
      .byte_i   (byte_q),
      .ext_o    (ext_s),
      .merged_o (merged_s)
   );

   assign timeout_s = WD_EN && (cnt_q == CNT_LAST);

   assign stall = ((state_q == ST_IDLE) && (mem_read || mem_write))
                || (state_q == ST_READ)   || (state_q == ST_WRITE)
                || (state_q == ST_RMW_RD) || (state_q == ST_RMW_WR);

   assign rdata     = rdata_q;
   assign done      = done_q;
   assign err       = err_q;
   assign bus_req   = req_q;
   assign bus_we    = we_q;
   assign bus_addr  = baddr_q;
   assign bus_wdata = bwdata_q;

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      byte_d   = byte_q;
      size_d   = size_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      done_d   = 1'b0;
      err_d    = err_q;
      req_d    = req_q;
      we_d     = we_q;
      baddr_d  = baddr_q;
      bwdata_d = bwdata_q;

      case (state_q)
         ST_IDLE: begin
            if (mem_read || mem_write) begin
               lane_d   = addr[LANE_W-1:0];
               byte_d   = wdata[BYTE_W-1:0];
               size_d   = mem_size;
               baddr_d  = {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
               bwdata_d = wdata;
               cnt_d    = '0;
               err_d    = 1'b0;
               if ((mem_read && mem_write) ||
                   ((mem_size == MEM_SIZE_WORD) && (addr[LANE_W-1:0] != 2'b00))) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = 32'h0000_0000;
               end else if (mem_read) begin
                  state_d = ST_READ;
                  req_d   = 1'b1;
                  we_d    = 1'b0;
               end else if (mem_size == MEM_SIZE_WORD) begin
                  state_d = ST_WRITE;
                  req_d   = 1'b1;
                  we_d    = 1'b1;
               end else begin
                  state_d = ST_RMW_RD;
                  req_d   = 1'b1;
                  we_d    = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_READ, ST_WRITE, ST_RMW_RD, ST_RMW_WR: begin
            if (bus_ack) begin
               case (state_q)
                  ST_RMW_RD: begin
                     // bus_req stays high into the write phase; only bus_we rises.
                     state_d  = ST_RMW_WR;
                     bwdata_d = merged_s;
                     we_d     = 1'b1;
                     cnt_d    = '0;
                  end
                  ST_READ: begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                     err_d   = 1'b0;
                     req_d   = 1'b0;
                     we_d    = 1'b0;
                     rdata_d = (size_q == MEM_SIZE_WORD) ? bus_rdata : ext_s;
                  end
                  default: begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                     err_d   = 1'b0;
                     req_d   = 1'b0;
                     we_d    = 1'b0;
                  end
               endcase
            end else if (timeout_s) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               req_d   = 1'b0;
               we_d    = 1'b0;
               rdata_d = 32'h0000_0000;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            err_d   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops bus_req with no completion pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         lane_q   <= '0;
         byte_q   <= '0;
         size_q   <= MEM_SIZE_WORD;
         cnt_q    <= '0;
         rdata_q  <= 32'h0000_0000;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         baddr_q  <= '0;
         bwdata_q <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         byte_q   <= byte_d;
         size_q   <= size_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         done_q   <= done_d;
         err_q    <= err_d;
         req_q    <= req_d;
         we_q     <= we_d;
         baddr_q  <= baddr_d;
         bwdata_q <= bwdata_d;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a reactive bus
// responder that acks each phase after a programmable number of wait cycles.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              mem_read = 1'b0, mem_write = 1'b0, mem_size = 1'b1;
   logic [ADDR_W-1:0] addr = 32'h0;
   logic [31:0]       wdata = 32'h0;
   logic              stall, done, err, bus_req, bus_we;
   logic [31:0]       rdata, bus_wdata;
   logic [ADDR_W-1:0] bus_addr;
   logic [31:0]       bus_rdata = 32'h0;
   logic              bus_ack = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   int          obs_lat, obs_stall, obs_req;
   logic        obs_gap, obs_we_any, obs_err, obs_stall_done, obs_done_next;
   logic [31:0] obs_rdata, obs_addr, obs_wword;

   mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .addr(addr), .wdata(wdata), .stall(stall),
      .rdata(rdata), .done(done), .err(err), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one request, answer each bus phase after wait_cyc idle cycles
   // (negative = never), and record what was seen up to the done cycle.
   task automatic run_op(input logic rd, input logic wr, input logic sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rw, input int wait_cyc);
      logic dropped;
      int   pc;
      mem_read = rd; mem_write = wr; mem_size = sz; addr = a; wdata = wd;
      obs_lat = -1; obs_stall = 0; obs_req = 0; obs_gap = 1'b0; obs_we_any = 1'b0;
      obs_err = 1'bx; obs_stall_done = 1'bx; obs_rdata = 32'hx;
      obs_addr = 32'hx; obs_wword = 32'hx;
      dropped = 1'b0; pc = 0;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (done) begin
            obs_lat = c + 1; obs_rdata = rdata; obs_err = err; obs_stall_done = stall;
            break;
         end
         obs_stall += int'(stall);
         if (bus_req) begin
            obs_req++;
            if (dropped) obs_gap = 1'b1;
            obs_addr = bus_addr;
            if (bus_we) begin obs_we_any = 1'b1; obs_wword = bus_wdata; end
            bus_ack = (pc == wait_cyc);
            pc = bus_ack ? 0 : pc + 1;
         end else begin
            bus_ack = 1'b0;
            if (obs_req > 0) dropped = 1'b1;
         end
         bus_rdata = rw;
         tick;
      end
      mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
      tick;
      obs_done_next = done;
   endtask

   task automatic test_reset;
      #3;
      n_cmp++; if ({bus_req, bus_we, done, err, stall} !== 5'b0) begin n_bad++;
         $display("FAIL reset_ctrl: got %b want 00000", {bus_req, bus_we, done, err, stall}); end
      n_cmp++; if (rdata !== 32'h0) begin n_bad++;
         $display("FAIL reset_rdata: got %h want 00000000", rdata); end
      n_cmp++; if ({bus_addr, bus_wdata} !== 64'h0) begin n_bad++;
         $display("FAIL reset_bus: got %h/%h want 0/0", bus_addr, bus_wdata); end
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      tick;
   endtask

   task automatic test_lw_wait;
      run_op(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 2);
      n_cmp++; if (obs_addr !== 32'h100 || obs_we_any !== 1'b0) begin n_bad++;
         $display("FAIL lw_bus: got addr %h we %b want 00000100 0", obs_addr, obs_we_any); end
      n_cmp++; if (obs_stall !== 4) begin n_bad++;
         $display("FAIL lw_stall_cycles: got %0d want 4", obs_stall); end
      n_cmp++; if (obs_lat !== 5) begin n_bad++;
         $display("FAIL lw_latency: got %0d want 5", obs_lat); end
      n_cmp++; if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin n_bad++;
         $display("FAIL lw_result: got %h err %b want deadbeef 0", obs_rdata, obs_err); end
      n_cmp++; if (obs_stall_done !== 1'b0 || obs_done_next !== 1'b0) begin n_bad++;
         $display("FAIL lw_done_pulse: got stall %b next %b want 0 0", obs_stall_done, obs_done_next); end
   endtask

   task automatic test_lb;
      run_op(1'b1, 1'b0, MEM_SIZE_BYTE, 32'h203, 32'h0, 32'h80123456, 0);
      n_cmp++; if (obs_addr !== 32'h200 || obs_lat !== 3) begin n_bad++;
         $display("FAIL lb3_bus: got addr %h lat %0d want 00000200 3", obs_addr, obs_lat); end
      n_cmp++; if (obs_rdata !== 32'hFFFFFF80 || obs_err !== 1'b0) begin n_bad++;
         $display("FAIL lb3_rdata: got %h err %b want ffffff80 0", obs_rdata, obs_err); end
      run_op(1'b1, 1'b0, MEM_SIZE_BYTE, 32'h201, 32'h0, 32'h80123456, 0);
      n_cmp++; if (obs_rdata !== 32'h00000034 || obs_err !== 1'b0) begin n_bad++;
         $display("FAIL lb1_rdata: got %h err %b want 00000034 0", obs_rdata, obs_err); end
   endtask

   task automatic test_sb_rmw;
      run_op(1'b0, 1'b1, MEM_SIZE_BYTE, 32'h302, 32'h000000AB, 32'h11223344, 0);
      n_cmp++; if (obs_wword !== 32'h11AB3344 || obs_addr !== 32'h300) begin n_bad++;
         $display("FAIL sb_merge: got %h @%h want 11ab3344 @00000300", obs_wword, obs_addr); end
      n_cmp++; if (obs_req !== 2 || obs_gap !== 1'b0 || obs_we_any !== 1'b1) begin n_bad++;
         $display("FAIL sb_req_continuous: got req %0d gap %b we %b want 2 0 1", obs_req, obs_gap, obs_we_any); end
      n_cmp++; if (obs_lat !== 4 || obs_err !== 1'b0) begin n_bad++;
         $display("FAIL sb_latency: got %0d err %b want 4 0", obs_lat, obs_err); end
      n_cmp++; if (obs_rdata !== 32'h00000034) begin n_bad++;
         $display("FAIL sb_rdata_held: got %h want 00000034", obs_rdata); end
   endtask

   task automatic test_sw;
      run_op(1'b0, 1'b1, MEM_SIZE_WORD, 32'h400, 32'hCAFEF00D, 32'h0, 0);
      n_cmp++; if (obs_wword !== 32'hCAFEF00D || obs_lat !== 3 || obs_req !== 1) begin n_bad++;
         $display("FAIL sw_write: got %h lat %0d req %0d want cafef00d 3 1", obs_wword, obs_lat, obs_req); end
      n_cmp++; if (obs_rdata !== 32'h00000034 || obs_err !== 1'b0) begin n_bad++;
         $display("FAIL sw_rdata_held: got %h err %b want 00000034 0", obs_rdata, obs_err); end
   endtask

   task automatic test_errors;
      run_op(1'b1, 1'b0, MEM_SIZE_WORD, 32'h102, 32'h0, 32'h0, 0);
      n_cmp++; if (obs_req !== 0 || obs_lat !== 2 || obs_err !== 1'b1) begin n_bad++;
         $display("FAIL misaligned: got req %0d lat %0d err %b want 0 2 1", obs_req, obs_lat, obs_err); end
      n_cmp++; if (obs_rdata !== 32'h0) begin n_bad++;
         $display("FAIL misaligned_rdata: got %h want 00000000", obs_rdata); end
      run_op(1'b1, 1'b1, MEM_SIZE_WORD, 32'h100, 32'h0, 32'h0, 0);
      n_cmp++; if (obs_req !== 0 || obs_lat !== 2 || obs_err !== 1'b1) begin n_bad++;
         $display("FAIL rd_and_wr: got req %0d lat %0d err %b want 0 2 1", obs_req, obs_lat, obs_err); end
   endtask

   task automatic test_timeout;
      run_op(1'b1, 1'b0, MEM_SIZE_WORD, 32'h500, 32'h0, 32'h12345678, TIMEOUT - 1);
      n_cmp++; if (obs_req !== 16 || obs_lat !== 18 || obs_err !== 1'b0 || obs_rdata !== 32'h12345678) begin n_bad++;
         $display("FAIL ack_at_limit: got req %0d lat %0d err %b rd %h want 16 18 0 12345678",
                  obs_req, obs_lat, obs_err, obs_rdata); end
      run_op(1'b0, 1'b1, MEM_SIZE_WORD, 32'h504, 32'h5A5A5A5A, 32'h0, -1);
      n_cmp++; if (obs_req !== 16 || obs_lat !== 18 || obs_err !== 1'b1) begin n_bad++;
         $display("FAIL timeout_abort: got req %0d lat %0d err %b want 16 18 1", obs_req, obs_lat, obs_err); end
      n_cmp++; if (obs_rdata !== 32'h0) begin n_bad++;
         $display("FAIL timeout_rdata: got %h want 00000000", obs_rdata); end
   endtask

   task automatic test_reset_mid_rmw;
      mem_write = 1'b1; mem_size = MEM_SIZE_BYTE; addr = 32'h600; wdata = 32'h55;
      bus_rdata = 32'hA0B0C0D0;
      tick;
      bus_ack = 1'b1;
      tick;
      bus_ack = 1'b0;
      n_cmp++; if ({bus_req, bus_we} !== 2'b11) begin n_bad++;
         $display("FAIL rmw_wr_phase: got req/we %b want 11", {bus_req, bus_we}); end
      #2; reset = 1'b0; #1;
      n_cmp++; if (bus_req !== 1'b0 || done !== 1'b0) begin n_bad++;
         $display("FAIL async_reset: got req %b done %b want 0 0", bus_req, done); end
      mem_write = 1'b0;
      tick;
      n_cmp++; if (done !== 1'b0 || bus_req !== 1'b0) begin n_bad++;
         $display("FAIL reset_no_done: got done %b req %b want 0 0", done, bus_req); end
      reset = 1'b1;
      tick;
      run_op(1'b1, 1'b0, MEM_SIZE_WORD, 32'h104, 32'h0, 32'h0BADF00D, 0);
      n_cmp++; if (obs_rdata !== 32'h0BADF00D || obs_err !== 1'b0 || obs_lat !== 3) begin n_bad++;
         $display("FAIL lw_after_reset: got %h err %b lat %0d want 0badf00d 0 3", obs_rdata, obs_err, obs_lat); end
   endtask

   initial begin
      test_reset;
      test_lw_wait;
      test_lb;
      test_sb_rmw;
      test_sw;
      test_errors;
      test_timeout;
      test_reset_mid_rmw;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
